// File: rtl/xor_arb_pkg.sv
// Shared types and constants for the round-robin XOR unit arbiter.
// Parity helper is used only when XOR_ARB_PARITY_EN is defined.
package xor_arb_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef logic req_id_t;

  // Zero-extension does not change the reduction XOR, so any WIDTH up to 64 fits.
  function automatic logic reduce_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/xor_core.sv
// Purely combinational WIDTH-bit bitwise XOR datapath shared by the arbiter.
module xor_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter sharing one xor_core between two valid/ready requesters.
// Optional macro XOR_ARB_PARITY_EN adds a registered resp_parity output.
module xor_unit_arbiter
  import xor_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
`ifdef XOR_ARB_PARITY_EN
  output logic             resp_parity,
`endif
  output logic             busy
);

  state_e           state_r;
  req_id_t          prio_r;
  req_id_t          id_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] core_y;
  logic             grant_vld;
  req_id_t          grant_id;

  xor_core #(.WIDTH(WIDTH)) u_core (
    .a (op_a_r),
    .b (op_b_r),
    .y (core_y)
  );

  // Contention goes to prio_r; a lone requester always wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end
      2'b10: begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
      2'b11: begin
        grant_vld = 1'b1;
        grant_id  = prio_r;
      end
      default: begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
      end
    endcase
  end

  // Handshake strobes decoded from the registered state.
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    if ((state_r == IDLE) && grant_vld) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
    if (state_r == RESP) begin
      resp_valid = id_r ? 2'b10 : 2'b01;
    end else begin
      resp_valid = 2'b00;
    end
  end

  assign busy = (state_r != IDLE);

  // Accept / compute / respond sequencing; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      prio_r      <= 1'b0;
      id_r        <= 1'b0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      resp_data   <= '0;
      resp_id     <= 1'b0;
`ifdef XOR_ARB_PARITY_EN
      resp_parity <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_vld) begin
            op_a_r  <= grant_id ? req_a1 : req_a0;
            op_b_r  <= grant_id ? req_b1 : req_b0;
            id_r    <= grant_id;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          resp_data   <= core_y;
          resp_id     <= id_r;
`ifdef XOR_ARB_PARITY_EN
          resp_parity <= reduce_parity(64'(core_y));
`endif
          state_r     <= RESP;
        end
        RESP: begin
          if (resp_ready[id_r]) begin
            prio_r  <= ~id_r;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
